// File: rtl/jedro_1_imem_arbiter_pkg.sv
// Shared types and sizing constants for the instruction-memory arbiter
// that sits between the fetch unit, the LSU and the code ROM.
package jedro_1_imem_arbiter_pkg;

    localparam int IMEM_DATA_WIDTH         = 32;
    localparam int IMEM_SIZE_BYTES         = 4096;
    localparam int IMEM_FETCH_STARVE_LIMIT = 4;

    // Which requester owns the ROM data coming back in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LSU   = 2'd2
    } imem_owner_t;

endpackage

// File: rtl/jedro_1_imem_arbiter.sv
// Arbitrates the single-port, 1-cycle-latency instruction ROM between fetch and LSU:
// LSU-first fixed priority with a fetch starvation guard, fetch flush, range errors.
module jedro_1_imem_arbiter
    import jedro_1_imem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH         = IMEM_DATA_WIDTH,
    parameter int MEM_SIZE_BYTES     = IMEM_SIZE_BYTES,
    parameter int FETCH_STARVE_LIMIT = IMEM_FETCH_STARVE_LIMIT
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  fetch_req_i,
    input  logic [DATA_WIDTH-1:0] fetch_addr_i,
    input  logic                  fetch_flush_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_rvalid_o,
    output logic [DATA_WIDTH-1:0] fetch_rdata_o,
    input  logic                  lsu_req_i,
    input  logic [DATA_WIDTH-1:0] lsu_addr_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  mem_en_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]      STARVE_MAX = CNT_W'(FETCH_STARVE_LIMIT);
    localparam logic [DATA_WIDTH-1:0] MEM_LIMIT  = DATA_WIDTH'(MEM_SIZE_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    imem_owner_t           owner_r;
    imem_owner_t           owner_nxt_s;
    logic                  oor_r;
    logic [CNT_W-1:0]      starve_r;
    logic [CNT_W-1:0]      starve_nxt_s;
    logic [DATA_WIDTH-1:0] mem_addr_r;

    logic                  fetch_wins_s;
    logic                  grant_any_s;
    logic                  grant_oor_s;
    logic [DATA_WIDTH-1:0] grant_addr_s;

    // Grant selection and ROM request; outputs are forced low while reset is asserted.
    always_comb begin
        fetch_wins_s = fetch_req_i && (!lsu_req_i || (starve_r == STARVE_MAX));
        fetch_gnt_o  = rstn_i && fetch_wins_s;
        lsu_gnt_o    = rstn_i && lsu_req_i && !fetch_wins_s;
        grant_any_s  = fetch_gnt_o || lsu_gnt_o;
        if (fetch_gnt_o) begin
            grant_addr_s = fetch_addr_i;
        end else begin
            grant_addr_s = lsu_addr_i;
        end
        grant_oor_s = grant_addr_s >= MEM_LIMIT;
        mem_en_o    = grant_any_s && !grant_oor_s;
        if (mem_en_o) begin
            mem_addr_o = grant_addr_s & ALIGN_MASK;
        end else begin
            mem_addr_o = mem_addr_r;
        end
    end

    // Next owner of the response phase and next starvation count.
    always_comb begin
        if (fetch_gnt_o) begin
            owner_nxt_s = OWN_FETCH;
        end else if (lsu_gnt_o) begin
            owner_nxt_s = OWN_LSU;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
        if (fetch_req_i && !fetch_gnt_o) begin
            if (starve_r == STARVE_MAX) begin
                starve_nxt_s = starve_r;
            end else begin
                starve_nxt_s = starve_r + CNT_W'(1);
            end
        end else begin
            starve_nxt_s = '0;
        end
    end

    // Response steering; a flush only kills the fetch response being returned right now,
    // so a fetch granted in the flush cycle still completes.
    always_comb begin
        fetch_rvalid_o = 1'b0;
        fetch_rdata_o  = '0;
        lsu_rvalid_o   = 1'b0;
        lsu_rdata_o    = '0;
        lsu_err_o      = 1'b0;
        case (owner_r)
            OWN_FETCH: begin
                fetch_rvalid_o = !fetch_flush_i;
                if (!fetch_flush_i && !oor_r) begin
                    fetch_rdata_o = mem_rdata_i;
                end else begin
                    fetch_rdata_o = '0;
                end
            end
            OWN_LSU: begin
                lsu_rvalid_o = 1'b1;
                lsu_err_o    = oor_r;
                if (oor_r) begin
                    lsu_rdata_o = '0;
                end else begin
                    lsu_rdata_o = mem_rdata_i;
                end
            end
            default: begin
                fetch_rvalid_o = 1'b0;
                lsu_rvalid_o   = 1'b0;
            end
        endcase
    end

    // Owner FSM, range flag, starvation counter and held ROM address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_r    <= OWN_NONE;
            oor_r      <= 1'b0;
            starve_r   <= '0;
            mem_addr_r <= '0;
        end else begin
            owner_r  <= owner_nxt_s;
            oor_r    <= grant_any_s && grant_oor_s;
            starve_r <= starve_nxt_s;
            if (mem_en_o) begin
                mem_addr_r <= mem_addr_o;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_imem_arbiter.sv
// Self-checking bench for jedro_1_imem_arbiter: directed vector table, randomized
// traffic against a transaction-level model, and an asynchronous reset sequence.
module tb_jedro_1_imem_arbiter;

    localparam int DW  = 32;
    localparam int MEM = 4096;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fetch_req = 1'b0;
    logic [DW-1:0] fetch_addr = '0;
    logic          fetch_flush = 1'b0;
    logic          fetch_gnt, fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          lsu_req = 1'b0;
    logic [DW-1:0] lsu_addr = '0;
    logic          lsu_gnt, lsu_rvalid, lsu_err;
    logic [DW-1:0] lsu_rdata;
    logic          mem_en;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    jedro_1_imem_arbiter #(
        .DATA_WIDTH(DW), .MEM_SIZE_BYTES(MEM), .FETCH_STARVE_LIMIT(LIM)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_flush_i(fetch_flush),
        .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
        .lsu_req_i(lsu_req), .lsu_addr_i(lsu_addr), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_err_o(lsu_err),
        .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    function automatic logic [DW-1:0] rom(input logic [DW-1:0] a);
        return 32'hC0DE_0000 ^ {2'b00, a[DW-1:2]};
    endfunction

    // Behavioural ROM with one cycle of read latency.
    always @(posedge clk) if (mem_en) mem_rdata <= rom(mem_addr);

    typedef struct {
        bit            fr;
        logic [DW-1:0] fa;
        bit            fl;
        bit            lr;
        logic [DW-1:0] la;
        bit            fg, lg, frv, lrv, lerr, men;
    } vec_t;

    typedef struct {
        bit            is_fetch;
        bit            oor;
        logic [DW-1:0] addr;
    } resp_t;

    resp_t         pend[$];
    int            starve = 0;
    logic [DW-1:0] last_maddr = '0;
    int            n_vec = 0;
    int            n_miss = 0;
    bit            last_fg = 1'b0;
    bit            last_lg = 1'b0;
    vec_t          tbl[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit fr, input logic [DW-1:0] fa, input bit fl,
                                input bit lr, input logic [DW-1:0] la,
                                input bit fg, input bit lg, input bit frv,
                                input bit lrv, input bit lerr, input bit men);
        vec_t v;
        v.fr = fr; v.fa = fa; v.fl = fl; v.lr = lr; v.la = la;
        v.fg = fg; v.lg = lg; v.frv = frv; v.lrv = lrv; v.lerr = lerr; v.men = men;
        return v;
    endfunction

    // One clock cycle: drive inputs, check against the model (and table), advance the model.
    task automatic cycle(input string tag, input bit use_tbl, input vec_t v);
        bit            e_fg, e_lg, e_men, e_frv, e_lrv, e_lerr;
        logic [DW-1:0] g_addr, e_maddr, e_frd, e_lrd;
        bit            g_oor;
        resp_t         r, nr;
        fetch_req = v.fr; fetch_addr = v.fa; fetch_flush = v.fl;
        lsu_req = v.lr; lsu_addr = v.la;
        @(negedge clk);
        e_fg   = v.fr && (!v.lr || starve >= LIM);
        e_lg   = v.lr && !e_fg;
        g_addr = e_fg ? v.fa : v.la;
        g_oor  = g_addr >= MEM;
        e_men  = (e_fg || e_lg) && !g_oor;
        e_maddr = e_men ? {g_addr[DW-1:2], 2'b00} : last_maddr;
        e_frv = 1'b0; e_lrv = 1'b0; e_lerr = 1'b0; e_frd = '0; e_lrd = '0;
        if (pend.size() > 0) begin
            r = pend[0];
            if (r.is_fetch) begin
                e_frv = !v.fl;
                e_frd = (e_frv && !r.oor) ? rom(r.addr) : '0;
            end else begin
                e_lrv  = 1'b1;
                e_lerr = r.oor;
                e_lrd  = r.oor ? '0 : rom(r.addr);
            end
        end
        n_vec++;
        chk({tag, " fetch_gnt"},    32'(fetch_gnt),    32'(e_fg));
        chk({tag, " lsu_gnt"},      32'(lsu_gnt),      32'(e_lg));
        chk({tag, " mem_en"},       32'(mem_en),       32'(e_men));
        chk({tag, " mem_addr"},     mem_addr,          e_maddr);
        chk({tag, " fetch_rvalid"}, 32'(fetch_rvalid), 32'(e_frv));
        chk({tag, " fetch_rdata"},  fetch_rdata,       e_frd);
        chk({tag, " lsu_rvalid"},   32'(lsu_rvalid),   32'(e_lrv));
        chk({tag, " lsu_err"},      32'(lsu_err),      32'(e_lerr));
        chk({tag, " lsu_rdata"},    lsu_rdata,         e_lrd);
        if (use_tbl) begin
            chk({tag, " tbl fetch_gnt"},    32'(fetch_gnt),    32'(v.fg));
            chk({tag, " tbl lsu_gnt"},      32'(lsu_gnt),      32'(v.lg));
            chk({tag, " tbl fetch_rvalid"}, 32'(fetch_rvalid), 32'(v.frv));
            chk({tag, " tbl lsu_rvalid"},   32'(lsu_rvalid),   32'(v.lrv));
            chk({tag, " tbl lsu_err"},      32'(lsu_err),      32'(v.lerr));
            chk({tag, " tbl mem_en"},       32'(mem_en),       32'(v.men));
        end
        @(posedge clk);
        if (pend.size() > 0) pend.delete(0);
        if (e_fg || e_lg) begin
            nr.is_fetch = e_fg; nr.oor = g_oor; nr.addr = g_addr;
            pend.push_back(nr);
        end
        starve = (v.fr && !e_fg) ? ((starve + 1 > LIM) ? LIM : starve + 1) : 0;
        if (e_men) last_maddr = e_maddr;
        last_fg = e_fg; last_lg = e_lg;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        n_vec++;
        chk({tag, " fetch_gnt"},    32'(fetch_gnt),    32'h0);
        chk({tag, " lsu_gnt"},      32'(lsu_gnt),      32'h0);
        chk({tag, " mem_en"},       32'(mem_en),       32'h0);
        chk({tag, " mem_addr"},     mem_addr,          32'h0);
        chk({tag, " fetch_rvalid"}, 32'(fetch_rvalid), 32'h0);
        chk({tag, " fetch_rdata"},  fetch_rdata,       32'h0);
        chk({tag, " lsu_rvalid"},   32'(lsu_rvalid),   32'h0);
        chk({tag, " lsu_err"},      32'(lsu_err),      32'h0);
        chk({tag, " lsu_rdata"},    lsu_rdata,         32'h0);
    endtask

    initial begin
        vec_t v;
        //            fr fa          fl lr la          fg lg frv lrv err men
        tbl.push_back(mk(1, 32'h0000, 0, 0, 32'h0000,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0004, 0, 0, 32'h0000,  1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0008, 0, 0, 32'h0000,  1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h000C, 0, 1, 32'h0100,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h000C, 0, 1, 32'h0100,  0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 32'h000C, 0, 1, 32'h0100,  0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 32'h000C, 0, 1, 32'h0100,  0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(1, 32'h000C, 0, 1, 32'h0100,  1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 32'h0010, 0, 1, 32'h0100,  0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0010, 0, 0, 32'h0000,  1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0010, 0, 0, 32'h0000,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 1, 0, 32'h0000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0040, 0, 0, 32'h0000,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h0050, 0, 0, 32'h0000,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0054, 1, 0, 32'h0000,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 1, 0, 32'h0000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 0, 1, 32'h2000,  0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 32'h0000,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0000, 0, 1, 32'h0020,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0024, 0, 0, 32'h0000,  1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 1, 32'h0020,  0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 32'h0024, 0, 0, 32'h0000,  1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0000, 0, 0, 32'h0000,  0, 0, 1, 0, 0, 0));

        // Requests raised while in reset must not be granted.
        fetch_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h0000_0100;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        fetch_req = 1'b0; lsu_req = 1'b0;

        for (int i = 0; i < tbl.size(); i++) cycle($sformatf("tbl%0d", i), 1'b1, tbl[i]);

        v = mk(0, '0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (!(v.fr && !last_fg)) begin
                v.fr = $urandom_range(0, 99) < 60;
                v.fa = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(MEM, 2 * MEM - 1)) & 32'hFFFF_FFFC)
                                                   : (32'($urandom_range(0, MEM / 4 - 1)) << 2);
            end
            if (!(v.lr && !last_lg)) begin
                v.lr = $urandom_range(0, 99) < 50;
                v.la = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(MEM, 3 * MEM))
                                                   : 32'($urandom_range(0, MEM - 1));
            end
            v.fl = $urandom_range(0, 9) == 0;
            cycle($sformatf("rnd%0d", i), 1'b0, v);
        end

        // Reset asserted between edges while a fetch response is being returned.
        cycle("pre_rst", 1'b0, mk(1, 32'h0008, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        fetch_req = 1'b1; fetch_addr = 32'h0000_000C;
        n_vec++;
        chk("pre_rst fetch_rvalid", 32'(fetch_rvalid), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        pend.delete(); starve = 0; last_maddr = '0;
        @(posedge clk); #1;
        fetch_req = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) cycle($sformatf("post_rst%0d", i), 1'b0,
                                          mk(0, '0, 0, 0, '0, 0, 0, 0, 0, 0, 0));
        cycle("post_rst_fetch", 1'b1, mk(1, 32'h0004, 0, 0, '0, 1, 0, 0, 0, 0, 1));
        cycle("post_rst_resp", 1'b1, mk(0, '0, 0, 0, '0, 0, 0, 1, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
